// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and tag types for the two-port memory arbiter.
package mem_arb_pkg;
   localparam int MEM_ARB_ADDR_W = 14;
   localparam int MEM_ARB_DATA_W = 8;
   localparam int MEM_ARB_RD_LAT = 3;
   typedef logic rq_id_t;
   typedef struct packed {
      logic   valid;
      rq_id_t id;
   } tag_t;
endpackage

// File: rtl/mem_arb_tagpipe.sv
// mem_arb_tagpipe: read-tag delay line matched to the memory read latency.
module mem_arb_tagpipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = MEM_ARB_RD_LAT
) (
   input  logic clk,
   input  logic rst_n,
   input  tag_t i_tag,
   output tag_t o_tag
);
   tag_t r_stage [DEPTH];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   assign o_tag = r_stage[DEPTH-1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between two requesters, one op per cycle.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = MEM_ARB_ADDR_W,
   parameter int DATA_W = MEM_ARB_DATA_W,
   parameter int RD_LAT = MEM_ARB_RD_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rq0_req,
   input  logic              rq0_we,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic [DATA_W-1:0] rq0_wdata,
   output logic              rq0_gnt,
   output logic              rq0_rvalid,
   output logic [DATA_W-1:0] rq0_rdata,
   input  logic              rq1_req,
   input  logic              rq1_we,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic [DATA_W-1:0] rq1_wdata,
   output logic              rq1_gnt,
   output logic              rq1_rvalid,
   output logic [DATA_W-1:0] rq1_rdata,
   output logic [ADDR_W-1:0] mem_addr_rd,
   input  logic [DATA_W-1:0] mem_q,
   output logic [ADDR_W-1:0] mem_addr_wr,
   output logic [DATA_W-1:0] mem_data_wr,
   output logic              mem_wren
);
   logic w_any, w_sel, w_we;
   tag_t w_tag_in, w_tag_out;
   // Gating with rst_n keeps grants and writes off while reset is held.
   assign w_any = rst_n && (rq0_req || rq1_req);
`ifdef MEM_ARB_RR_EN
   logic r_last;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_last <= 1'b1;
      else if (w_any) r_last <= w_sel;
   assign w_sel = (rq0_req && rq1_req) ? ~r_last : rq1_req;
`else
   assign w_sel = rq1_req && !rq0_req;
`endif
   assign rq0_gnt     = w_any && !w_sel;
   assign rq1_gnt     = w_any && w_sel;
   assign w_we        = w_sel ? rq1_we : rq0_we;
   assign mem_addr_rd = w_any ? (w_sel ? rq1_addr : rq0_addr) : '0;
   assign mem_addr_wr = mem_addr_rd;
   assign mem_data_wr = w_any ? (w_sel ? rq1_wdata : rq0_wdata) : '0;
   assign mem_wren    = w_any && w_we;
   assign w_tag_in    = '{valid: w_any && !w_we, id: w_sel};
   mem_arb_tagpipe #(.DEPTH(RD_LAT)) u_tagpipe (
      .clk   (clk),
      .rst_n (rst_n),
      .i_tag (w_tag_in),
      .o_tag (w_tag_out)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rq0_rvalid <= 1'b0;
         rq1_rvalid <= 1'b0;
         rq0_rdata  <= '0;
         rq1_rdata  <= '0;
      end else begin
         rq0_rvalid <= w_tag_out.valid && !w_tag_out.id;
         rq1_rvalid <= w_tag_out.valid && w_tag_out.id;
         if (w_tag_out.valid && !w_tag_out.id) rq0_rdata <= mem_q;
         if (w_tag_out.valid && w_tag_out.id) rq1_rdata <= mem_q;
      end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue-based model of the arbiter and a 3-stage memory.
module tb_mem_arbiter;
   localparam int AW = 14;
   localparam int DW = 8;
   localparam int LAT = 3;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rq0_req = 1'b0, rq0_we = 1'b0, rq1_req = 1'b0, rq1_we = 1'b0;
   logic [AW-1:0] rq0_addr = '0, rq1_addr = '0;
   logic [DW-1:0] rq0_wdata = '0, rq1_wdata = '0;
   logic          rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, mem_wren;
   logic [DW-1:0] rq0_rdata, rq1_rdata, mem_q, mem_data_wr;
   logic [AW-1:0] mem_addr_rd, mem_addr_wr;
   int            errors = 0;
   int            checks = 0;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
      .rq0_gnt(rq0_gnt), .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
      .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
      .rq1_gnt(rq1_gnt), .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
      .mem_addr_rd(mem_addr_rd), .mem_q(mem_q), .mem_addr_wr(mem_addr_wr),
      .mem_data_wr(mem_data_wr), .mem_wren(mem_wren)
   );

   always #5 clk = ~clk;

   // memory block: address register, array read register, output register
   logic [DW-1:0] mem [1 << AW];
   logic [AW-1:0] m_a = '0;
   logic [DW-1:0] m_d = '0, m_q = '0;
   always @(posedge clk) begin
      m_a <= mem_addr_rd;
      m_d <= mem[m_a];
      m_q <= m_d;
      if (mem_wren) mem[mem_addr_wr] <= mem_data_wr;
   end
   assign mem_q = m_q;

   // model: shadow memory plus a queue of pending read returns with due edge numbers
   typedef struct {
      logic          id;
      logic [DW-1:0] data;
      int            due;
   } rd_t;
   rd_t           q[$];
   logic [DW-1:0] shadow [1 << AW];
   int            n_edge = 0;
   logic          m_last = 1'b1;
   logic          m_rv [2] = '{1'b0, 1'b0};
   logic [DW-1:0] m_rd [2] = '{8'h00, 8'h00};

   function automatic logic [1:0] pred_gnt();
      if (!rst_n || !(rq0_req || rq1_req)) return 2'b00;
      if (rq0_req && rq1_req) return (RR && !m_last) ? 2'b10 : 2'b01;
      return rq0_req ? 2'b01 : 2'b10;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [1:0] g;
      rd_t        r;
      logic       id;
      logic [AW-1:0] a;
      if (!rst_n) begin
         q.delete();
         m_last = 1'b1;
         m_rv = '{1'b0, 1'b0};
         m_rd = '{8'h00, 8'h00};
      end else begin
         n_edge++;
         g = pred_gnt();
         m_rv = '{1'b0, 1'b0};
         if (q.size() > 0 && q[0].due == n_edge) begin
            r = q.pop_front();
            m_rv[r.id] = 1'b1;
            m_rd[r.id] = r.data;
         end
         if (g != 2'b00) begin
            id = g[1];
            a = id ? rq1_addr : rq0_addr;
            if (id ? rq1_we : rq0_we) shadow[a] = id ? rq1_wdata : rq0_wdata;
            else q.push_back('{id: id, data: shadow[a], due: n_edge + LAT});
            m_last = id;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) if ($time > 6) begin
      logic [1:0] g;
      logic [AW-1:0] ea;
      g  = pred_gnt();
      ea = g[1] ? rq1_addr : rq0_addr;
      chk("gnt0", rq0_gnt, g[0]);
      chk("gnt1", rq1_gnt, g[1]);
      chk("mem_addr_rd", mem_addr_rd, g != 0 ? ea : '0);
      chk("mem_addr_wr", mem_addr_wr, g != 0 ? ea : '0);
      chk("mem_data_wr", mem_data_wr, g != 0 ? (g[1] ? rq1_wdata : rq0_wdata) : '0);
      chk("mem_wren", mem_wren, g != 0 && (g[1] ? rq1_we : rq0_we));
      chk("rvalid0", rq0_rvalid, m_rv[0]);
      chk("rvalid1", rq1_rvalid, m_rv[1]);
      chk("rdata0", rq0_rdata, m_rd[0]);
      chk("rdata1", rq1_rdata, m_rd[1]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem[i] = '0;
         shadow[i] = '0;
      end
      mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
      shadow[1] = 8'h11; shadow[2] = 8'h22; shadow[3] = 8'h33;
      rq0_req = 1'b1; rq0_we = 1'b1; rq0_addr = 14'h0005; rq0_wdata = 8'h77;
      tick();
      #1;
      chk("rst_gnt0", rq0_gnt, 0);
      chk("rst_wren", mem_wren, 0);
      chk("rst_rvalid0", rq0_rvalid, 0);
      chk("rst_rdata0", rq0_rdata, 0);
      chk("rst_rdata1", rq1_rdata, 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rel_gnt0", rq0_gnt, 1);
      tick();
      // write 0xA5 then read it back on the next edge
      rq0_we = 1'b1; rq0_addr = 14'h0010; rq0_wdata = 8'hA5;
      tick();
      rq0_we = 1'b0;
      tick();
      rq0_req = 1'b0;
      tick();
      tick();
      #1;
      chk("raw_early", rq0_rvalid, 0);
      tick();
      #1;
      chk("raw_rvalid0", rq0_rvalid, 1);
      chk("raw_rdata0", rq0_rdata, 8'hA5);
      chk("raw_rvalid1", rq1_rvalid, 0);
      tick();
      #1;
      chk("raw_pulse_end", rq0_rvalid, 0);
      chk("raw_hold", rq0_rdata, 8'hA5);
      // back-to-back mixed reads
      rq0_req = 1'b1; rq0_addr = 14'h0001;
      tick();
      rq0_req = 1'b0; rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 14'h0002;
      tick();
      rq1_req = 1'b0; rq0_req = 1'b1; rq0_addr = 14'h0003;
      tick();
      rq0_req = 1'b0;
      tick();
      #1;
      chk("mix_a_rv0", rq0_rvalid, 1);
      chk("mix_a_rd0", rq0_rdata, 8'h11);
      tick();
      #1;
      chk("mix_b_rv1", rq1_rvalid, 1);
      chk("mix_b_rv0", rq0_rvalid, 0);
      chk("mix_b_rd1", rq1_rdata, 8'h22);
      tick();
      #1;
      chk("mix_c_rv0", rq0_rvalid, 1);
      chk("mix_c_rd0", rq0_rdata, 8'h33);
      tick();
      // read in flight dropped by a one-cycle reset
      rq1_req = 1'b1; rq1_addr = 14'h0002;
      tick();
      rst_n = 1'b0; rq1_req = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         chk("rstmid_rv1", rq1_rvalid, 0);
      end
      chk("rstmid_rd1", rq1_rdata, 0);
      rq1_req = 1'b1;
      tick();
      rq1_req = 1'b0;
      tick();
      tick();
      tick();
      #1;
      chk("post_rst_rv1", rq1_rvalid, 1);
      chk("post_rst_rd1", rq1_rdata, 8'h22);
      tick();
      // contention
      rq0_req = 1'b1; rq0_addr = 14'h0001; rq1_req = 1'b1; rq1_addr = 14'h0003;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("cont_gnt0", rq0_gnt, RR ? (k % 2 == 0) : 1);
         tick();
      end
      rq0_req = 1'b0; rq1_req = 1'b0;
      repeat (5) tick();
      // cancel: rq1 loses, then withdraws
      rq0_req = 1'b1; rq0_we = 1'b1; rq0_addr = 14'h0020; rq0_wdata = 8'h5A;
      rq1_req = 1'b1; rq1_we = 1'b1; rq1_addr = 14'h0030; rq1_wdata = 8'h99;
      #1;
      chk("cancel_gnt1", rq1_gnt, 0);
      chk("cancel_data", mem_data_wr, 8'h5A);
      tick();
      rq0_req = 1'b0; rq1_req = 1'b0;
      #1;
      chk("cancel_wren", mem_wren, 0);
      repeat (5) tick();
      chk("cancel_mem30", mem[14'h0030], 8'h00);
      chk("cancel_mem20", mem[14'h0020], 8'h5A);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
